// File: rtl/alu_regfile_unit.sv
// Execution core of the multicycle MIPS datapath: a 2-read/1-write register file
// with asynchronous reads, and a combinational ALU with a zero flag.
module alu_regfile_unit #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we3,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  input  logic [$clog2(NREGS)-1:0] wa3,
  input  logic [WIDTH-1:0]         wd3,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [2:0]               alucont,
  output logic [WIDTH-1:0]         result,
  output logic                     zero
);

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic             slt_bit;

  // Reset wins over a same-edge write; address 0 is never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we3 && (wa3 != '0)) begin
      regs[wa3] <= wd3;
    end
  end

  // No write-through bypass: a read of wa3 returns the old value until the edge.
  assign rd1 = (ra1 == AW'(0)) ? '0 : regs[ra1];
  assign rd2 = (ra2 == AW'(0)) ? '0 : regs[ra2];

  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    case (alucont)
      3'b000:  result = a & b;
      3'b001:  result = a | b;
      3'b010:  result = a + b;
      3'b011:  result = '0;
      3'b100:  result = a & ~b;
      3'b101:  result = a | ~b;
      3'b110:  result = a - b;
      3'b111:  result = {{(WIDTH-1){1'b0}}, slt_bit};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Directed and randomized checks of alu_regfile_unit against an array register model
// and an arithmetic ALU reference.
module tb_alu_regfile_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [4:0]  ra1, ra2, wa3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;
  logic [31:0] a, b;
  logic [2:0]  alucont;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [32];

  always #5 clk = ~clk;

  alu_regfile_unit #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
    .wd3(wd3), .rd1(rd1), .rd2(rd2), .a(a), .b(b), .alucont(alucont),
    .result(result), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x + y;
      3'd4:    return x & ~y;
      3'd5:    return x | ~y;
      3'd6:    return x - y;
      3'd7:    return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Applies one clock edge and mirrors the architectural effect in the model.
  task automatic edge_and_model();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (we3 && wa3 != 5'd0) begin
      model_regs[wa3] = wd3;
    end
    #1;
  endtask

  task automatic alu_check(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op,
                           input string tag);
    logic [31:0] r;
    a = x; b = y; alucont = op;
    #1;
    r = alu_ref(x, y, op);
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (r == 32'd0)});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'hxxxx_xxxx;
    reset = 1'b1; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
    a = '0; b = '0; alucont = 3'd0;

    // Reset clears every register on both ports.
    edge_and_model();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check("reset_rd1", rd1, 32'd0);
      check("reset_rd2", rd2, 32'd0);
    end

    // Write r8: old value visible before the edge, new value right after.
    we3 = 1'b1; wa3 = 5'd8; wd3 = 32'h1234_5678; ra1 = 5'd8; ra2 = 5'd8;
    #1;
    check("no_bypass", rd1, 32'd0);
    edge_and_model();
    check("write_r8_rd1", rd1, 32'h1234_5678);
    check("write_r8_rd2", rd2, 32'h1234_5678);

    // Writes to r0 are discarded; we3=0 leaves the target alone.
    wa3 = 5'd0; wd3 = 32'hFFFF_FFFF; ra1 = 5'd0;
    edge_and_model();
    check("r0_stays_zero", rd1, 32'd0);
    we3 = 1'b0; wa3 = 5'd8; wd3 = 32'hCAFE_F00D; ra1 = 5'd8;
    edge_and_model();
    check("we3_low_no_write", rd1, 32'h1234_5678);

    // Directed ALU vectors.
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd0, "and");
    check("and_val", result, 32'h8);
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd1, "or");
    check("or_val", result, 32'hE);
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd2, "add");
    check("add_val", result, 32'h16);
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd6, "sub");
    check("sub_val", result, 32'h2);
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd4, "andn");
    check("andn_val", result, 32'h4);
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd5, "orn");
    check("orn_val", result, 32'hFFFF_FFFD);
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd7, "slt");
    check("slt_val", result, 32'h0);
    alu_check(32'h0000_000C, 32'h0000_000A, 3'd3, "op3");
    check("op3_val", result, 32'h0);
    alu_check(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd6, "sub_eq");
    check("sub_eq_zero", {31'd0, zero}, 32'd1);
    alu_check(32'hFFFF_FFFF, 32'h0000_0001, 3'd2, "add_wrap");
    check("add_wrap_zero", {31'd0, zero}, 32'd1);
    alu_check(32'hFFFF_FFFF, 32'h0000_0001, 3'd7, "slt_neg");
    check("slt_neg_val", result, 32'd1);
    alu_check(32'h8000_0000, 32'h7FFF_FFFF, 3'd7, "slt_ovf");
    check("slt_ovf_val", result, 32'd1);
    alu_check(32'h7FFF_FFFF, 32'h8000_0000, 3'd7, "slt_ovf_rev");
    check("slt_ovf_rev_val", result, 32'd0);

    // Reset wins over a simultaneous write, then a plain write lands.
    reset = 1'b1; we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hAA; ra1 = 5'd5; ra2 = 5'd8;
    edge_and_model();
    check("reset_wins_r5", rd1, 32'd0);
    check("reset_clears_r8", rd2, 32'd0);
    reset = 1'b0;
    edge_and_model();
    check("r5_after_write", rd1, 32'hAA);

    // Random register traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 31) == 0);
      we3   = ($urandom_range(0, 3) != 0);
      wa3   = 5'($urandom_range(0, 31));
      wd3   = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
      ra2   = ($urandom_range(0, 7) == 0) ? ra1 : 5'($urandom_range(0, 31));
      #1;
      check("rand_rd1", rd1, (ra1 == 5'd0) ? 32'd0 : model_regs[ra1]);
      check("rand_rd2", rd2, (ra2 == 5'd0) ? 32'd0 : model_regs[ra2]);
      edge_and_model();
    end
    reset = 1'b0; we3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      check("final_sweep", rd1, (i == 0) ? 32'd0 : model_regs[i]);
    end

    // Random ALU operations with corner operands mixed in.
    for (int n = 0; n < 300; n++) begin
      alu_check(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)), "rand_alu");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
